// File: rtl/uart_char_rx.sv
// uart_char_rx: 8N1 serial character receiver with a one-entry valid/ready
// holding register, framing/overrun reporting and a received-byte counter.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames with a
// PARITY state and a live par_err pulse; otherwise par_err is tied to 0.
module uart_char_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       par_err,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic [7:0] rx_count
);

  localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] BIT_M1  = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state_q;
  logic        rxMeta_q;
  logic        rxSync_q;
  logic        rx_s;
  logic        armed_q;
  logic [7:0]  timer_q;
  logic [2:0]  bitIdx_q;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        frame_err_q;
  logic        overrun_q;
  logic [7:0]  rx_count_q;
  logic [7:0]  rx_count_d;
`ifdef UART_RX_PARITY_EN
  logic        parBit_q;
  logic        par_err_q;
`endif

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  assign rx_s = rxSync_q;

  // Next shift-register contents (LSB first) and next byte count.
  always_comb begin
    shift_d    = {rx_s, shift_q[7:1]};
    rx_count_d = rx_count_q + 8'd1;
  end

  // Receive FSM: bit timing, byte assembly, holding register and status.
  // Later assignments in this block deliberately override earlier ones so
  // that a load beats a transfer-clear and an overrun set beats ovr_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      timer_q     <= 8'd0;
      bitIdx_q    <= 3'd0;
      shift_q     <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_count_q  <= 8'd0;
`ifdef UART_RX_PARITY_EN
      parBit_q    <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (ovr_clr) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!armed_q) begin
            armed_q <= rx_s;
          end else if (!rx_s) begin
            state_q <= START;
            timer_q <= 8'd0;
          end
        end

        START: begin
          if (timer_q == HALF_M1) begin
            timer_q <= 8'd0;
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              state_q  <= DATA;
              bitIdx_q <= 3'd0;
            end
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end

        DATA: begin
          if (timer_q == BIT_M1) begin
            timer_q <= 8'd0;
            shift_q <= shift_d;
            if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer_q == BIT_M1) begin
            timer_q  <= 8'd0;
            parBit_q <= rx_s;
            state_q  <= STOP;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
`endif

        STOP: begin
          if (timer_q == BIT_M1) begin
            timer_q <= 8'd0;
            state_q <= IDLE;
            armed_q <= rx_s;
            if (!rx_s) begin
              frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift_q, parBit_q}) begin
              par_err_q <= 1'b1;
`endif
            end else if (!rx_valid_q || rx_ready) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              rx_count_q <= rx_count_d;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_count  = rx_count_q;
`ifdef UART_RX_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_char_rx.sv
// tb_uart_char_rx: self-checking bench for uart_char_rx with a byte
// scoreboard. Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_char_rx;

  localparam int N = 16;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       ovr_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       par_err;
  logic       overrun;
  logic [7:0] rx_count;

  int checks = 0;
  int failures = 0;
  int deliverCnt = 0;
  int frameErrCnt = 0;
  int parErrCnt = 0;
  logic [7:0] sbQ[$];

  uart_char_rx #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .par_err  (par_err),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .rx_count (rx_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor on the falling edge: count error pulses, score delivered bytes.
  always @(negedge clk) begin
    if (frame_err === 1'b1) frameErrCnt++;
    if (par_err === 1'b1) parErrCnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      deliverCnt++;
      checkOutput("sb_pending", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, sbQ.pop_front()});
      end
    end
  end

  // Hold the line at one level for a number of cycles.
  task automatic driveBit(input logic v, input int len);
    rx = v;
    repeat (len) @(posedge clk);
    #1;
  endtask

  // Send one serial frame; stop level and length are selectable.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int stopLen, input logic parBit);
    driveBit(1'b0, N);
    for (int i = 0; i < 8; i++) driveBit(data[i], N);
`ifdef UART_RX_PARITY_EN
    driveBit(parBit, N);
`endif
    driveBit(stopBit, stopLen);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_data"},    {24'd0, rx_data},  32'd0);
    checkOutput({pfx, "_valid"},   {31'd0, rx_valid}, 32'd0);
    checkOutput({pfx, "_ferr"},    {31'd0, frame_err}, 32'd0);
    checkOutput({pfx, "_perr"},    {31'd0, par_err},  32'd0);
    checkOutput({pfx, "_overrun"}, {31'd0, overrun},  32'd0);
    checkOutput({pfx, "_count"},   {24'd0, rx_count}, 32'd0);
  endtask

  // Stimulus sequence.
  initial begin
    int d0;
    int f0;
    int p0;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Plain byte with consumer ready.
    d0 = deliverCnt; f0 = frameErrCnt;
    sbQ.push_back(8'h55);
    applyStimulus(8'h55, 1'b1, N, ^8'h55);
    driveBit(1'b1, 2 * N);
    checkOutput("t1_deliver", deliverCnt - d0, 1);
    checkOutput("t1_count", {24'd0, rx_count}, 32'd1);
    checkOutput("t1_ferr", frameErrCnt - f0, 0);
    checkOutput("t1_sb_empty", sbQ.size(), 0);

    // False start: a short low glitch delivers nothing.
    resetDut();
    d0 = deliverCnt; f0 = frameErrCnt;
    driveBit(1'b0, 4);
    driveBit(1'b1, 3 * N);
    checkOutput("t2_deliver", deliverCnt - d0, 0);
    checkOutput("t2_count", {24'd0, rx_count}, 32'd0);
    checkOutput("t2_ferr", frameErrCnt - f0, 0);
    sbQ.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1, N, ^8'h5A);
    driveBit(1'b1, 2 * N);
    checkOutput("t2_recover", deliverCnt - d0, 1);

    // Framing error followed by a held-low line.
    resetDut();
    d0 = deliverCnt; f0 = frameErrCnt;
    applyStimulus(8'hA3, 1'b0, 4 * N, ^8'hA3);
    checkOutput("t3_ferr", frameErrCnt - f0, 1);
    checkOutput("t3_valid", {31'd0, rx_valid}, 32'd0);
    driveBit(1'b1, 2 * N);
    checkOutput("t3_ferr_once", frameErrCnt - f0, 1);
    checkOutput("t3_deliver", deliverCnt - d0, 0);
    checkOutput("t3_count", {24'd0, rx_count}, 32'd0);

    // Overrun with a stalled consumer.
    resetDut();
    rx_ready = 1'b0;
    sbQ.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, N, ^8'h11);
    driveBit(1'b1, 2 * N);
    applyStimulus(8'h22, 1'b1, N, ^8'h22);
    driveBit(1'b1, 2 * N);
    checkOutput("t4_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("t4_data", {24'd0, rx_data}, 32'h11);
    checkOutput("t4_overrun", {31'd0, overrun}, 32'd1);
    checkOutput("t4_count", {24'd0, rx_count}, 32'd1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    checkOutput("t4_ovr_clr", {31'd0, overrun}, 32'd0);
    d0 = deliverCnt;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4_drain", deliverCnt - d0, 1);
    checkOutput("t4_valid_clr", {31'd0, rx_valid}, 32'd0);

    // Shortest stop bit followed immediately by the next start bit.
    resetDut();
    d0 = deliverCnt;
    sbQ.push_back(8'h3C);
    sbQ.push_back(8'hC3);
    applyStimulus(8'h3C, 1'b1, H + 1, ^8'h3C);
    applyStimulus(8'hC3, 1'b1, N, ^8'hC3);
    driveBit(1'b1, 2 * N);
    checkOutput("t5_deliver", deliverCnt - d0, 2);
    checkOutput("t5_count", {24'd0, rx_count}, 32'd2);

    // 256 back-to-back bytes; the counter wraps to zero.
    resetDut();
    d0 = deliverCnt; f0 = frameErrCnt;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      sbQ.push_back(b);
      applyStimulus(b, 1'b1, N, ^b);
    end
    driveBit(1'b1, 2 * N);
    checkOutput("t6_deliver", deliverCnt - d0, 256);
    checkOutput("t6_count_wrap", {24'd0, rx_count}, 32'd0);
    checkOutput("t6_data_last", {24'd0, rx_data}, 32'hFF);
    checkOutput("t6_ferr", frameErrCnt - f0, 0);
    checkOutput("t6_sb_empty", sbQ.size(), 0);

    // Reset in the middle of a 257th frame aborts it silently.
    d0 = deliverCnt; f0 = frameErrCnt;
    driveBit(1'b0, N);
    driveBit(1'b1, N);
    driveBit(1'b0, N);
    driveBit(1'b1, N / 2);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    driveBit(1'b1, 12 * N);
    checkOutput("t7_deliver", deliverCnt - d0, 0);
    checkOutput("t7_ferr", frameErrCnt - f0, 0);
    checkOutput("t7_count", {24'd0, rx_count}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: correct parity bit delivers, wrong bit pulses par_err.
    resetDut();
    d0 = deliverCnt; p0 = parErrCnt;
    sbQ.push_back(8'h07);
    applyStimulus(8'h07, 1'b1, N, 1'b1);
    driveBit(1'b1, 2 * N);
    checkOutput("par_good_deliver", deliverCnt - d0, 1);
    applyStimulus(8'h07, 1'b1, N, 1'b0);
    driveBit(1'b1, 2 * N);
    checkOutput("par_bad_perr", parErrCnt - p0, 1);
    checkOutput("par_bad_deliver", deliverCnt - d0, 1);
    checkOutput("par_count", {24'd0, rx_count}, 32'd1);
`else
    p0 = parErrCnt;
    checkOutput("perr_never", p0, 0);
`endif

    checkOutput("sb_final_empty", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
